// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB-first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-1:0]  ss;
  logic          c;
  logic [CW-1:0] cnt;
  logic          s;
  logic          co;

  // Team full-adder cell, returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign {co, s} = full_add(sa[0], sb[0], c);

  // Control FSM, operand/sum shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ss    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= {1'b0, sa[N-1:1]};
          sb  <= {1'b0, sb[N-1:1]};
          ss  <= {s, ss[N-1:1]};
          c   <= co;
          cnt <= cnt + CW'(1);
          // Last bit: c is the carry into the MSB, co the carry out of it.
          if (cnt == CW'(N - 1)) begin
            sum   <= {s, ss[N-1:1]};
            cout  <= co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= c ^ co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed plan steps plus random adds
// compared against an arithmetic reference model.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
  logic         exp_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] exp_sum;
  logic         exp_cout;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain (N+1)-bit arithmetic plus the signed-overflow rule.
  task automatic model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
    logic [N:0] full;
    full     = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    exp_sum  = full[N-1:0];
    exp_cout = full[N];
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf  = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
`endif
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // One complete add from IDLE; operands are scrambled right after accept.
  task automatic run_add(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic ci, input logic scramble);
    logic [N-1:0] prev_sum;
    prev_sum = exp_sum;
    start = 1'b1; a = x; b = y; cin = ci;
    tick();
    start = 1'b0;
    if (scramble) begin
      a = '0; b = '0; cin = 1'b0;
    end else begin
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".nodone"}, 32'(done), 32'd0);
      if (i == N / 2) chk({tag, ".hold"}, 32'(sum), 32'(prev_sum));
      tick();
    end
    model(x, y, ci);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    check_result(tag);
    tick();
    chk({tag, ".done_low"}, 32'(done), 32'd0);
    check_result({tag, ".held"});
  endtask

  initial begin
    int dones;
    int last_done;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    check_result("rst");

    run_add("t1", 8'h25, 8'h17, 1'b0, 1'b0);
    chk("t1.value", 32'(sum), 32'h3C);
    run_add("t2a", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_add("t2b", 8'h00, 8'h00, 1'b1, 1'b0);
    chk("t2b.value", 32'(sum), 32'h01);
    run_add("t4", 8'hAA, 8'h55, 1'b0, 1'b1);
    chk("t4.value", 32'(sum), 32'hFF);

    // Held start: adds repeat every N+2 cycles, one done each.
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    model(8'h10, 8'h20, 1'b0);
    dones = 0; last_done = -1;
    for (int cyc = 0; cyc < 4 * (N + 2); cyc++) begin
      tick();
      if (done) begin
        if (last_done >= 0) chk("t3.period", 32'(cyc - last_done), 32'(N + 2));
        check_result("t3");
        dones++;
        last_done = cyc;
      end
    end
    start = 1'b0;
    chk("t3.count", 32'(dones), 32'd4);
    for (int i = 0; i < N + 2; i++) tick();

    // Reset in the 4th SHIFT cycle aborts the add without a done.
    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf = 1'b0;
`endif
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.done", 32'(done), 32'd0);
    check_result("t5");
    dones = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (done) dones++;
      tick();
    end
    chk("t5.nodone", 32'(dones), 32'd0);
    run_add("t5b", 8'h03, 8'h04, 1'b0, 1'b0);
    chk("t5b.value", 32'(sum), 32'h07);

    run_add("t6a", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_add("t6b", 8'hFF, 8'hFF, 1'b0, 1'b0);
    run_add("edge", 8'hFF, 8'hFF, 1'b1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_add("rnd", N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around the team's 1-bit full-adder equations. The block feeds operand bits LSB-first into a single full-adder cell and consumes its {carry, sum} pair: a carry flip-flop holds the carry, and a shift register collects the sum bits. It trades N cycles of latency for one adder cell. A start/done handshake lets a controller launch an add and collect the result.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request an add; sampled only in IDLE
a  input  N  operand A; captured on accepted start
b  input  N  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while bits are being processed (SHIFT)
done  output  1  one-cycle pulse; result valid
sum  output  N  registered sum; held until the next completion
cout  output  1  registered carry-out; held with sum

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset. No other clock or reset.
- Reset (reset=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry and bit counter are cleared. Reset wins over every other input, including mid-operation. An interrupted add produces no done.
- Bit cell, combinational on the current LSBs: s = a0 ^ b0 ^ c; co = (a0&b0) | (a0&c) | (b0&c). This must match the team full-adder truth table exactly.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at edge: load sa<=a, sb<=b, c<=cin, cnt<=0, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - busy=1.
  - Each edge: sa, sb shift right by 1; s shifts into the MSB of the sum shift register (ss); c<=co; cnt<=cnt+1.
  - When cnt==N-1 at the edge, the last bit is processed: sum<=final ss (including this bit), cout<=co, then go to DONE.
  - start is ignored in this state.
- DONE:
  - done=1, busy=0 for exactly one cycle, then go to IDLE unconditionally.
  - start is ignored in DONE. A new request must be presented in IDLE.
- Latency: start accepted at edge k gives busy=1 for cycles k+1..k+N. done=1 in the cycle after edge k+N, i.e. N+1 cycles after the accept edge. Back-to-back throughput is one add per N+2 cycles.
- Widths: cnt is $clog2(N) bits. Arithmetic is modulo 2^N; the carry out of bit N-1 goes to cout. There is no saturation.
- sum/cout change only on the edge entering DONE or on reset. Between completions they hold their value, so a consumer may sample them any time after done.
- a, b, cin may change freely after the accept edge without affecting the result.

Optional Feature:
SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - ovf <= carry into bit N-1 XOR carry out of bit N-1 (two's-complement signed overflow).
  - Loaded on the same edge as sum/cout and held with them.
- Undefined:
  - Port ovf is absent.
  - No signed-overflow logic is synthesised.
  - All other behaviour is identical.

Test Plan:
1. N=8, a=0x25, b=0x17, cin=0, start pulse -> busy high 8 cycles; done pulse 9 cycles after the accept edge; sum=0x3C, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. The second add starts the cycle after done returns to IDLE.
3. Hold start=1 continuously with a=0x10, b=0x20 -> start is ignored during SHIFT/DONE; re-accepted in IDLE; adds repeat every 10 cycles with sum=0x30 and one done per add.
4. Start a=0xAA, b=0x55; change a, b to 0x00 on the next cycle -> result is still sum=0xFF, cout=0.
5. Assert reset during the 4th SHIFT cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows. A later add of 0x03+0x04 gives sum=0x07.
6. With SERIAL_ADDER_OVF_EN defined: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. 0xFF+0xFF -> sum=0xFE, cout=1, ovf=0.
